lifo_arbiter: RTL and testbench

LIFO_ARBITER -- requirements
Module: lifo_arbiter

---
 rtl/lifo_arbiter.sv | 137 +++++++++++++
 tb/tb_lifo_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one external LIFO among NUM_REQ requesters, tracking occupancy itself.
// Optional macro LIFO_ARB_ERR_EN: ineligible requests are granted and answered with rsp_err.
module lifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           data_wr,
  output logic                            wr_en,
  output logic                            rd_en,
  input  logic [DATA_WIDTH-1:0]           data_rd,
  output logic [$clog2(DEPTH+1)-1:0]      count
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ-1);

  typedef enum logic {IDLE, POP_WAIT} state_t;

  state_t               state;
  logic [IDX_W-1:0]     last_granted;
  logic [IDX_W-1:0]     pop_idx_p1;
  logic                 vld_p0;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_op;
  logic                 gnt_elig;
  logic                 not_full;
  logic                 not_empty;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   cand;
`ifdef LIFO_ARB_ERR_EN
  logic                 pop_err_p1;
`endif

  // Requester index k positions after base, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Stage p0: eligibility, round-robin pick and combinational grant/LIFO strobes
  always_comb begin
    not_full  = (count < CNT_MAX);
    not_empty = (count != '0);
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && (req_op[i] ? not_empty : not_full);
`ifdef LIFO_ARB_ERR_EN
    cand = req_valid;
`else
    cand = elig;
`endif
    vld_p0  = 1'b0;
    gnt_idx = '0;
    // Scan farthest-first so the closest candidate after last_granted wins.
    if (state == IDLE && !rst) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (cand[rr_idx(last_granted, k)]) begin
          vld_p0  = 1'b1;
          gnt_idx = rr_idx(last_granted, k);
        end
      end
    end
    gnt_op   = req_op[gnt_idx];
    gnt_elig = elig[gnt_idx];

    req_grant = '0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    data_wr   = '0;
    if (vld_p0) begin
      req_grant[gnt_idx] = 1'b1;
      wr_en = gnt_elig && !gnt_op;
      rd_en = gnt_elig && gnt_op;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (wr_en && gnt_idx == IDX_W'(i))
        data_wr = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage p1: response presented while waiting on the LIFO read data
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (state == POP_WAIT && !rst) begin
      rsp_valid[pop_idx_p1] = 1'b1;
`ifdef LIFO_ARB_ERR_EN
      rsp_err  = pop_err_p1;
      rsp_data = pop_err_p1 ? '0 : data_rd;
`else
      rsp_data = data_rd;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      last_granted <= IDX_LAST;
      pop_idx_p1   <= '0;
`ifdef LIFO_ARB_ERR_EN
      pop_err_p1   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (vld_p0) begin
            last_granted <= gnt_idx;
            pop_idx_p1   <= gnt_idx;
            if (wr_en) count <= count + 1'b1;
            if (rd_en) count <= count - 1'b1;
            if (gnt_op || !gnt_elig) state <= POP_WAIT;
`ifdef LIFO_ARB_ERR_EN
            pop_err_p1 <= !gnt_elig;
`endif
          end
        end
        POP_WAIT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomized and directed bench for lifo_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_lifo_arbiter;
  localparam int N  = 4;
  localparam int D  = 12;
  localparam int W  = 8;
  localparam int CW = $clog2(D+1);
`ifdef LIFO_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_op = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_grant, rsp_valid;
  logic [W-1:0]   rsp_data, data_wr, data_rd;
  logic           rsp_err, wr_en, rd_en;
  logic [CW-1:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lifo_arbiter #(.NUM_REQ(N), .DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .data_wr(data_wr), .wr_en(wr_en), .rd_en(rd_en), .data_rd(data_rd), .count(count)
  );

  // External LIFO: registered read data, valid the cycle after rd_en.
  logic [W-1:0] lifo_q[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lifo_q.delete();
      data_rd <= '0;
    end else if (wr_en) begin
      lifo_q.push_back(data_wr);
    end else if (rd_en && lifo_q.size() > 0) begin
      data_rd <= lifo_q[$];
      void'(lifo_q.pop_back());
    end
  end

  // Reference model state
  logic [W-1:0] m_stack[$];
  int           m_last;
  bit           m_wait;
  bit           m_perr;
  int           m_pidx;
  logic [W-1:0] m_pdata;
  int           wait_cnt[N];
  logic [N-1:0] last_gnt;
  logic [W-1:0] last_rsp;
  logic         last_err;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_last = N-1;
    m_wait = 1'b0;
    m_perr = 1'b0;
    m_pidx = 0;
    m_pdata = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  function automatic bit m_elig(int i);
    return req_op[i] ? (m_stack.size() > 0) : (m_stack.size() < D);
  endfunction

  task automatic set_req(int i, bit op, logic [W-1:0] d);
    req_valid[i] = 1'b1;
    req_op[i] = op;
    req_data[i*W +: W] = d;
  endtask

  // One clock: predict, compare at the falling edge, advance model, release granted request.
  task automatic cycle();
    logic [N-1:0] e_gnt, e_rsp;
    logic         e_wr, e_rd, e_err;
    logic [W-1:0] e_wdata, e_rdata;
    int           win;
    e_gnt = '0; e_rsp = '0; e_wr = 1'b0; e_rd = 1'b0; e_err = 1'b0;
    e_wdata = '0; e_rdata = '0; win = -1;
    @(negedge clk);
    if (rst) model_reset();
    check("count", count, m_stack.size());
    if (!rst) begin
      if (m_wait) begin
        e_rsp[m_pidx] = 1'b1;
        e_rdata = m_pdata;
        e_err = m_perr;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (win < 0 && req_valid[i] && (ERR_EN || m_elig(i))) win = i;
        end
        if (win >= 0) begin
          e_gnt[win] = 1'b1;
          if (m_elig(win)) begin
            e_wr = !req_op[win];
            e_rd = req_op[win];
          end
          e_wdata = req_data[win*W +: W];
        end
      end
    end
    check("grant", req_grant, e_gnt);
    check("wr_en", wr_en, e_wr);
    check("rd_en", rd_en, e_rd);
    if (e_wr || rst) check("data_wr", data_wr, e_wr ? e_wdata : '0);
    check("rsp_valid", rsp_valid, e_rsp);
    check("rsp_err", rsp_err, e_err);
    if (e_rsp != '0 || rst) check("rsp_data", rsp_data, e_rdata);
    last_gnt = req_grant;
    if (rsp_valid != '0) begin
      last_rsp = rsp_data;
      last_err = rsp_err;
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || !(ERR_EN || m_elig(i)) || rst) wait_cnt[i] = 0;
      else if (win == i) begin
        check("starve_bound", wait_cnt[i] < N, 1'b1);
        wait_cnt[i] = 0;
      end else if (win >= 0) wait_cnt[i]++;
    end
    if (!rst) begin
      if (m_wait) m_wait = 1'b0;
      else if (win >= 0) begin
        m_last = win;
        if (e_wr) m_stack.push_back(e_wdata);
        else begin
          m_wait = 1'b1;
          m_pidx = win;
          m_perr = !e_rd;
          m_pdata = e_rd ? m_stack.pop_back() : '0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (win >= 0) req_valid[win] = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int guard;
    int bias;
    model_reset();
    last_rsp = '0;
    last_err = 1'b0;
    // Requests held through reset must not be granted while rst is high.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h10 + 8'(i));
    cycle();
    cycle();
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      cycle();
      exp_g = '0;
      exp_g[k] = 1'b1;
      check("req019_order", last_gnt, exp_g);
    end
    check("req019_count", count, 4);

    for (int k = 0; k < 4; k++) begin
      last_rsp = '0;
      set_req(2, 1'b1, '0);
      cycle();
      check("req020_grant", last_gnt, 4'b0100);
      cycle();
      check("req020_data", last_rsp, 8'h13 - 8'(k));
    end
    check("req020_count", count, 0);

    for (int k = 0; k < D; k++) begin
      set_req(0, 1'b0, 8'h20 + 8'(k));
      cycle();
    end
    check("req021_full", count, D);
    set_req(1, 1'b0, 8'hAA);
    repeat (3) cycle();
`ifndef LIFO_ARB_ERR_EN
    check("req021_stall", last_gnt, 4'b0000);
    set_req(3, 1'b1, '0);
    cycle();
    check("req021_pop_grant", last_gnt, 4'b1000);
    cycle();
    check("req021_pop_data", last_rsp, 8'h2B);
    cycle();
    check("req021_push_grant", last_gnt, 4'b0010);
    check("req021_count", count, D);
`else
    check("req021_err", last_err, 1'b1);
    set_req(3, 1'b1, '0);
    repeat (3) cycle();
    check("req021_pop_data", last_rsp, 8'h2B);
`endif
    repeat (2) cycle();

    guard = 0;
    while (m_stack.size() > 0 && guard < 4*D) begin
      set_req(0, 1'b1, '0);
      cycle();
      cycle();
      guard++;
    end
    check("req022_empty", count, 0);
    set_req(2, 1'b1, '0);
`ifndef LIFO_ARB_ERR_EN
    repeat (3) cycle();
    check("req022_nogrant", last_gnt, 4'b0000);
    set_req(0, 1'b0, 8'h55);
    cycle();
    check("req022_push_first", last_gnt, 4'b0001);
    cycle();
    check("req022_pop_grant", last_gnt, 4'b0100);
    cycle();
    check("req022_pop_data", last_rsp, 8'h55);
`else
    cycle();
    check("req022_err_grant", last_gnt, 4'b0100);
    cycle();
    check("req022_err_flag", last_err, 1'b1);
    check("req022_err_count", count, 0);
`endif
    repeat (2) cycle();

    set_req(1, 1'b0, 8'h77);
    cycle();
    set_req(2, 1'b1, '0);
    cycle();
    rst = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
    cycle();
    check("req023_count", count, 0);
    set_req(1, 1'b0, 8'h01);
    set_req(3, 1'b0, 8'h03);
    set_req(0, 1'b0, 8'h00);
    cycle();
    check("req023_first", last_gnt, 4'b0001);

    for (int c = 0; c < 3000; c++) begin
      bias = ((c / 150) % 2 == 0) ? 3 : 1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, ($urandom_range(0, 3) < bias) ? 1'b0 : 1'b1, 8'($urandom));
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
